xa_arbiter: RTL and testbench



---
 rtl/xa_pkg.sv | 31 +++
 rtl/xa_datapath.sv | 57 +++++
 rtl/xa_arbiter.sv | 120 ++++++++++++
 tb/tb_xa_arbiter.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/xa_pkg.sv
// Shared types and constants for the two-requester add-XOR arbiter.
// Optional statistics counters are enabled with the XA_STATS_EN macro.
package xa_pkg;

    localparam int unsigned XA_W    = 8;
    localparam int unsigned XA_NREQ = 2;
    localparam int unsigned XA_CNTW = 16;

    localparam logic [XA_W-1:0] XA_ADD_K = 8'h22;
    localparam logic [XA_W-1:0] XA_SEED  = 8'h03;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_CLR   = 2'd2
    } xa_state_e;

    // Operand captured into stage 1: owner, value and the owner's prior history
    typedef struct packed {
        logic            id;
        logic [XA_W-1:0] x;
        logic [XA_W-1:0] h;
    } xa_op_t;

    function automatic logic [XA_W-1:0] xa_func(input logic [XA_W-1:0] x,
                                                input logic [XA_W-1:0] h,
                                                input logic [XA_W-1:0] k);
        return XA_W'(x + k) ^ h;
    endfunction

endpackage

// File: rtl/xa_datapath.sv
// Two-stage add-XOR pipe: S1 holds the accepted operand, S2 holds the tagged result.
module xa_datapath
    import xa_pkg::*;
#(
    parameter logic [XA_W-1:0] ADD_K = XA_ADD_K
) (
    input  logic            clk,
    input  logic            clear_n,
    input  logic            i_load,
    input  logic            i_hold,
    input  xa_op_t          i_op,
    output logic            o_s1_full,
    output logic            o_s2_full,
    output logic            o_id,
    output logic [XA_W-1:0] o_data
);

    logic            r_s1_full;
    xa_op_t          r_s1;
    logic            r_s2_full;
    logic            r_s2_id;
    logic [XA_W-1:0] r_s2_data;
    logic [XA_W-1:0] w_y;

    assign w_y = xa_func(r_s1.x, r_s1.h, ADD_K);

    // S2 keeps its last result when not refilled so the output holds while idle
    always_ff @(posedge clk) begin
        if (!clear_n) begin
            r_s1_full <= 1'b0;
            r_s1      <= '0;
            r_s2_full <= 1'b0;
            r_s2_id   <= 1'b0;
            r_s2_data <= '0;
        end else begin
            if (!i_hold) begin
                r_s2_full <= r_s1_full;
                if (r_s1_full) begin
                    r_s2_id   <= r_s1.id;
                    r_s2_data <= w_y;
                end
            end
            if (i_load) begin
                r_s1_full <= 1'b1;
                r_s1      <= i_op;
            end else if (!i_hold) begin
                r_s1_full <= 1'b0;
            end
        end
    end

    assign o_s1_full = r_s1_full;
    assign o_s2_full = r_s2_full;
    assign o_id      = r_s2_id;
    assign o_data    = r_s2_data;

endmodule

// File: rtl/xa_arbiter.sv
// Round-robin front end, per-requester history and drain/reseed FSM around xa_datapath.
// Define XA_STATS_EN to add saturating per-requester accept counters.
module xa_arbiter
    import xa_pkg::*;
#(
    parameter logic [XA_W-1:0] ADD_K = XA_ADD_K,
    parameter logic [XA_W-1:0] SEED  = XA_SEED
) (
    input  logic               clk,
    input  logic               clear_n,
    input  logic [XA_NREQ-1:0] req_valid,
    input  logic [XA_W-1:0]    req_data0,
    input  logic [XA_W-1:0]    req_data1,
    output logic [XA_NREQ-1:0] req_ready,
    output logic               out_valid,
    output logic               out_id,
    output logic [XA_W-1:0]    out_data,
    input  logic               out_ready,
    input  logic               soft_clr,
    output logic               busy
`ifdef XA_STATS_EN
    ,
    output logic [XA_CNTW-1:0] stat_cnt0,
    output logic [XA_CNTW-1:0] stat_cnt1
`endif
);

    xa_state_e       r_state;
    logic            r_rr;
    logic [XA_W-1:0] r_h0;
    logic [XA_W-1:0] r_h1;

    logic            w_s1_full;
    logic            w_s2_full;
    logic            w_hold;
    logic            w_open;
    logic            w_gnt_id;
    logic            w_accept;
    xa_op_t          w_op;

    // Grant only in RUN, with no clear pending, when S1 is free at the edge
    assign w_hold   = w_s2_full && !out_ready;
    assign w_open   = clear_n && (r_state == ST_RUN) && !soft_clr
                      && (!w_s1_full || !w_hold);
    assign w_gnt_id = (req_valid == 2'b11) ? r_rr : req_valid[1];
    assign w_accept = w_open && (req_valid != 2'b00);

    assign req_ready = !w_accept ? 2'b00 : (w_gnt_id ? 2'b10 : 2'b01);

    assign w_op.id = w_gnt_id;
    assign w_op.x  = w_gnt_id ? req_data1 : req_data0;
    assign w_op.h  = w_gnt_id ? r_h1 : r_h0;

    xa_datapath #(
        .ADD_K(ADD_K)
    ) u_dp (
        .clk      (clk),
        .clear_n  (clear_n),
        .i_load   (w_accept),
        .i_hold   (w_hold),
        .i_op     (w_op),
        .o_s1_full(w_s1_full),
        .o_s2_full(w_s2_full),
        .o_id     (out_id),
        .o_data   (out_data)
    );

    // FSM, round-robin pointer and histories
    always_ff @(posedge clk) begin
        if (!clear_n) begin
            r_state <= ST_RUN;
            r_rr    <= 1'b0;
            r_h0    <= SEED;
            r_h1    <= SEED;
        end else begin
            if (w_accept) begin
                r_rr <= ~w_gnt_id;
                if (w_gnt_id) r_h1 <= req_data1;
                else          r_h0 <= req_data0;
            end
            case (r_state)
                ST_RUN: begin
                    if (soft_clr) r_state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (!w_s1_full && !w_s2_full) r_state <= ST_CLR;
                end
                ST_CLR: begin
                    r_state <= ST_RUN;
                    r_rr    <= 1'b0;
                    r_h0    <= SEED;
                    r_h1    <= SEED;
                end
                default: r_state <= ST_RUN;
            endcase
        end
    end

    assign out_valid = w_s2_full;
    assign busy      = (r_state != ST_RUN) || w_s1_full || w_s2_full;

`ifdef XA_STATS_EN
    logic [XA_CNTW-1:0] r_cnt0;
    logic [XA_CNTW-1:0] r_cnt1;

    always_ff @(posedge clk) begin
        if (!clear_n || (r_state == ST_CLR)) begin
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else if (w_accept) begin
            if (w_gnt_id && (r_cnt1 != '1))       r_cnt1 <= r_cnt1 + XA_CNTW'(1);
            else if (!w_gnt_id && (r_cnt0 != '1)) r_cnt0 <= r_cnt0 + XA_CNTW'(1);
        end
    end

    assign stat_cnt0 = r_cnt0;
    assign stat_cnt1 = r_cnt1;
`endif

endmodule

// File: tb/tb_xa_arbiter.sv
// Bench for xa_arbiter: directed vector table, hand sequences and a randomized scoreboard run.
module tb_xa_arbiter;
    import xa_pkg::*;

    logic       clk = 1'b0;
    logic       clear_n;
    logic [1:0] req_valid;
    logic [7:0] req_data0;
    logic [7:0] req_data1;
    logic [1:0] req_ready;
    logic       out_valid;
    logic       out_id;
    logic [7:0] out_data;
    logic       out_ready;
    logic       soft_clr;
    logic       busy;
`ifdef XA_STATS_EN
    logic [15:0] stat_cnt0;
    logic [15:0] stat_cnt1;
`endif

    always #5 clk = ~clk;

    xa_arbiter dut (
        .clk      (clk),
        .clear_n  (clear_n),
        .req_valid(req_valid),
        .req_data0(req_data0),
        .req_data1(req_data1),
        .req_ready(req_ready),
        .out_valid(out_valid),
        .out_id   (out_id),
        .out_data (out_data),
        .out_ready(out_ready),
        .soft_clr (soft_clr),
        .busy     (busy)
`ifdef XA_STATS_EN
        ,
        .stat_cnt0(stat_cnt0),
        .stat_cnt1(stat_cnt1)
`endif
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0] v;
        logic [7:0] d0;
        logic [7:0] d1;
        logic       ordy;
        logic       sclr;
        logic [1:0] e_rdy;
        logic       e_ov;
        logic       e_id;
        logic [7:0] e_dat;
        logic       e_busy;
    } vec_t;

    vec_t tbl[$];

    task automatic addv(input logic [1:0] v, input logic [7:0] d0, input logic [7:0] d1,
                        input logic ordy, input logic sclr, input logic [1:0] e_rdy,
                        input logic e_ov, input logic e_id, input logic [7:0] e_dat,
                        input logic e_busy);
        vec_t r;
        r.v = v; r.d0 = d0; r.d1 = d1; r.ordy = ordy; r.sclr = sclr;
        r.e_rdy = e_rdy; r.e_ov = e_ov; r.e_id = e_id; r.e_dat = e_dat; r.e_busy = e_busy;
        tbl.push_back(r);
    endtask

    task automatic drive(input logic [1:0] v, input logic [7:0] d0, input logic [7:0] d1,
                         input logic ordy, input logic sclr);
        req_valid = v; req_data0 = d0; req_data1 = d1; out_ready = ordy; soft_clr = sclr;
    endtask

    task automatic do_reset();
        clear_n = 1'b0;
        drive(2'b11, 8'h00, 8'h00, 1'b1, 1'b0);
        @(posedge clk);
        @(negedge clk);
        clear_n = 1'b1;
        drive(2'b00, 8'h00, 8'h00, 1'b1, 1'b0);
    endtask

    // Reference model state
    typedef struct {
        logic       id;
        logic [7:0] d;
        int         t;
    } item_t;

    item_t      m_q[$];
    logic [7:0] m_h[2];
    logic       m_rr;
    int         m_mode;   // 0 run, 1 draining, 2 reseeding
    int         m_cyc;
    logic       m_last_id;
    logic [7:0] m_last_d;

    task automatic model_reset();
        m_q.delete();
        m_h[0] = XA_SEED; m_h[1] = XA_SEED;
        m_rr = 1'b0; m_mode = 0; m_cyc = 0;
        m_last_id = 1'b0; m_last_d = 8'h00;
    endtask

    initial begin
        clear_n = 1'b0;
        drive(2'b00, 8'h00, 8'h00, 1'b1, 1'b0);

        // Reset state, checked while reset is still asserted
        @(posedge clk);
        req_valid = 2'b11;
        @(posedge clk);
        #1;
        chk("rst_req_ready", 16'(req_ready), 16'h0);
        chk("rst_out_valid", 16'(out_valid), 16'h0);
        chk("rst_out_id",    16'(out_id),    16'h0);
        chk("rst_out_data",  16'(out_data),  16'h0);
        chk("rst_busy",      16'(busy),      16'h0);
        @(negedge clk);
        clear_n = 1'b1;
        drive(2'b00, 8'h00, 8'h00, 1'b1, 1'b0);

        //    v      d0     d1     ordy  sclr  rdy    ov    id    data   busy
        addv(2'b01, 8'h10, 8'h00, 1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 8'h00, 1'b0);
        addv(2'b01, 8'h05, 8'h00, 1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 8'h00, 1'b1);
        addv(2'b00, 8'h00, 8'h00, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 8'h31, 1'b1);
        addv(2'b00, 8'h00, 8'h00, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 8'h37, 1'b1);
        addv(2'b00, 8'h00, 8'h00, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 8'h37, 1'b0);
        addv(2'b10, 8'h00, 8'hE0, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 8'h37, 1'b0);
        addv(2'b00, 8'h00, 8'h00, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 8'h37, 1'b1);
        addv(2'b00, 8'h00, 8'h00, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 8'h01, 1'b1);
        addv(2'b11, 8'hAA, 8'hBB, 1'b0, 1'b0, 2'b01, 1'b1, 1'b1, 8'h01, 1'b1);
        addv(2'b11, 8'hAA, 8'hBB, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 8'h01, 1'b1);
        addv(2'b11, 8'hAA, 8'hBB, 1'b1, 1'b0, 2'b10, 1'b1, 1'b1, 8'h01, 1'b1);
        addv(2'b00, 8'h00, 8'h00, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 8'hC9, 1'b1);
        addv(2'b00, 8'h00, 8'h00, 1'b1, 1'b0, 2'b00, 1'b1, 1'b1, 8'h3D, 1'b1);
        addv(2'b00, 8'h00, 8'h00, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 8'h3D, 1'b0);
        addv(2'b01, 8'h10, 8'h00, 1'b1, 1'b0, 2'b01, 1'b0, 1'b1, 8'h3D, 1'b0);
        addv(2'b01, 8'h20, 8'h00, 1'b1, 1'b1, 2'b00, 1'b0, 1'b1, 8'h3D, 1'b1);
        addv(2'b01, 8'h20, 8'h00, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 8'h98, 1'b1);
        addv(2'b01, 8'h20, 8'h00, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 8'h98, 1'b1);
        addv(2'b01, 8'h33, 8'h00, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 8'h98, 1'b1);
        addv(2'b11, 8'h10, 8'h77, 1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 8'h98, 1'b0);
        addv(2'b00, 8'h00, 8'h00, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 8'h98, 1'b1);
        addv(2'b00, 8'h00, 8'h00, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 8'h31, 1'b1);
        addv(2'b00, 8'h00, 8'h00, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 8'h31, 1'b0);

        foreach (tbl[i]) begin
            drive(tbl[i].v, tbl[i].d0, tbl[i].d1, tbl[i].ordy, tbl[i].sclr);
            #1;
            chk($sformatf("tbl%0d_req_ready", i), 16'(req_ready), 16'(tbl[i].e_rdy));
            chk($sformatf("tbl%0d_out_valid", i), 16'(out_valid), 16'(tbl[i].e_ov));
            chk($sformatf("tbl%0d_out_id", i),    16'(out_id),    16'(tbl[i].e_id));
            chk($sformatf("tbl%0d_out_data", i),  16'(out_data),  16'(tbl[i].e_dat));
            chk($sformatf("tbl%0d_busy", i),      16'(busy),      16'(tbl[i].e_busy));
            @(posedge clk);
            @(negedge clk);
        end

        // Reset mid-stream: in-flight operand is dropped, histories reseeded
        drive(2'b01, 8'h55, 8'h00, 1'b1, 1'b0);
        @(posedge clk);
        @(negedge clk);
        drive(2'b10, 8'h66, 8'h00, 1'b1, 1'b0);
        @(posedge clk);
        @(negedge clk);
        chk("mid_pre_valid", 16'(out_valid), 16'h1);
        clear_n = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_rst_valid", 16'(out_valid), 16'h0);
        chk("mid_rst_busy",  16'(busy),      16'h0);
        chk("mid_rst_ready", 16'(req_ready), 16'h0);
        @(negedge clk);
        clear_n = 1'b1;
        drive(2'b10, 8'h00, 8'h00, 1'b1, 1'b0);
        #1;
        chk("mid_post_ready", 16'(req_ready), 16'h2);
        chk("mid_post_valid", 16'(out_valid), 16'h0);
        @(posedge clk);
        @(negedge clk);
        drive(2'b00, 8'h00, 8'h00, 1'b1, 1'b0);
        chk("mid_post_valid2", 16'(out_valid), 16'h0);
        @(posedge clk);
        @(negedge clk);
        chk("mid_res_valid", 16'(out_valid), 16'h1);
        chk("mid_res_id",    16'(out_id),    16'h1);
        chk("mid_res_data",  16'(out_data),  16'h21);

        // Randomized run against the scoreboard model
        do_reset();
        model_reset();
        for (int c = 0; c < 4000; c++) begin
            logic [1:0] v;
            logic [7:0] d0, d1;
            logic       ordy, sclr, exp_ov, open, gid, ok_out;
            logic [1:0] exp_rdy;
            int         n;
            v    = 2'($urandom_range(0, 3));
            d0   = 8'($urandom);
            d1   = 8'($urandom);
            ordy = ($urandom_range(0, 3) != 0);
            sclr = ($urandom_range(0, 80) == 0);
            drive(v, d0, d1, ordy, sclr);
            #1;
            n       = m_q.size();
            exp_ov  = (n > 0) && (m_cyc > m_q[0].t);
            open    = (m_mode == 0) && !sclr && ((n < 2) || (exp_ov && ordy));
            gid     = (v == 2'b11) ? m_rr : v[1];
            exp_rdy = (open && v != 2'b00) ? (gid ? 2'b10 : 2'b01) : 2'b00;
            ok_out  = exp_ov && ordy;
            chk("rnd_req_ready", 16'(req_ready), 16'(exp_rdy));
            chk("rnd_out_valid", 16'(out_valid), 16'(exp_ov));
            chk("rnd_busy",      16'(busy),      16'((m_mode != 0) || (n > 0)));
            if (exp_ov) begin
                chk("rnd_out_id",   16'(out_id),   16'(m_q[0].id));
                chk("rnd_out_data", 16'(out_data), 16'(m_q[0].d));
            end else begin
                chk("rnd_hold_id",   16'(out_id),   16'(m_last_id));
                chk("rnd_hold_data", 16'(out_data), 16'(m_last_d));
            end
            @(posedge clk);
            m_cyc++;
            if (ok_out) begin
                m_last_id = m_q[0].id;
                m_last_d  = m_q[0].d;
                void'(m_q.pop_front());
            end
            if (exp_rdy != 2'b00) begin
                item_t it;
                logic [7:0] x;
                x     = gid ? d1 : d0;
                it.id = gid;
                it.d  = 8'(x + XA_ADD_K) ^ m_h[gid];
                it.t  = m_cyc;
                m_q.push_back(it);
                m_h[gid] = x;
                m_rr     = ~gid;
            end
            if (m_mode == 0 && sclr) begin
                m_mode = 1;
            end else if (m_mode == 1 && n == 0) begin
                m_mode = 2;
            end else if (m_mode == 2) begin
                m_mode = 0;
                m_rr   = 1'b0;
                m_h[0] = XA_SEED;
                m_h[1] = XA_SEED;
            end
            @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
